// File: rtl/ula_ctrl.sv
// ula_ctrl: multi-cycle sequencer and 4-entry register file driving the ULA.
// Optional zero flag output enabled by defining ULA_CTRL_ZERO_FLAG_EN.
module ula_ctrl #(
  parameter int ULA_OP = 3,
  parameter int BITS   = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  input  logic [7:0]        instr_in,
  output logic [ULA_OP-1:0] ula_op_out,
  output logic [BITS-1:0]   a_out,
  output logic [BITS-1:0]   b_out,
  input  logic [BITS-1:0]   result_in,
  input  logic [1:0]        rd_sel_in,
  output logic [BITS-1:0]   rd_data_out,
  output logic              busy_out,
  output logic              illegal_out,
`ifdef ULA_CTRL_ZERO_FLAG_EN
  output logic              zero_out,
`endif
  output logic              halted_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_IMM,
    S_HALT
  } state_t;

  state_t          state;
  logic [BITS-1:0] r [4];
  logic [1:0]      ra_q;

  logic       xfer;
  logic [3:0] opc;
  logic [1:0] ra;
  logic [1:0] rb;
  logic       is_alu;
  logic       is_ldi;
  logic       is_halt;

  assign opc     = instr_in[7:4];
  assign ra      = instr_in[3:2];
  assign rb      = instr_in[1:0];
  assign is_alu  = ~instr_in[7];
  assign is_ldi  = (opc == 4'b1000);
  assign is_halt = (opc == 4'b1111);

  // Ready is masked while reset is held so nothing is accepted mid-reset.
  assign instr_ready_out = rst_n_in &
    ((state == S_IDLE) | (state == S_IMM));
  assign xfer        = instr_valid_in & instr_ready_out;
  assign busy_out    = (state == S_EXEC) | (state == S_IMM);
  assign halted_out  = (state == S_HALT);
  assign rd_data_out = r[rd_sel_in];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= S_IDLE;
      ra_q        <= '0;
      ula_op_out  <= '0;
      a_out       <= '0;
      b_out       <= '0;
      illegal_out <= 1'b0;
`ifdef ULA_CTRL_ZERO_FLAG_EN
      zero_out    <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (xfer) begin
            unique case (1'b1)
              is_alu: begin
                ula_op_out <= ULA_OP'(instr_in[6:4]);
                a_out      <= r[ra];
                b_out      <= r[rb];
                ra_q       <= ra;
                state      <= S_EXEC;
              end
              is_ldi: begin
                ra_q  <= ra;
                state <= S_IMM;
              end
              is_halt: state <= S_HALT;
              default: illegal_out <= 1'b1;
            endcase
          end
        end
        S_EXEC: begin
          r[ra_q] <= result_in;
`ifdef ULA_CTRL_ZERO_FLAG_EN
          zero_out <= (result_in == '0);
`endif
          state <= S_IDLE;
        end
        S_IMM: begin
          if (xfer) begin
            r[ra_q] <= BITS'(instr_in);
`ifdef ULA_CTRL_ZERO_FLAG_EN
            zero_out <= (instr_in == 8'h00);
`endif
            state <= S_IDLE;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: randomized self-checking bench for ula_ctrl.
// Define ULA_CTRL_ZERO_FLAG_EN to also check the zero flag.
module tb_ula_ctrl;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            ready;
  logic [7:0]      instr = 8'h00;
  logic [2:0]      ula_op;
  logic [BITS-1:0] a, b, res, rd_data;
  logic [1:0]      rd_sel = 2'd0;
  logic            busy, illegal, halted;
`ifdef ULA_CTRL_ZERO_FLAG_EN
  logic            zero;
`endif

  int tests = 0;
  int fails = 0;

  int  m [4];
  bit  m_ill;
  bit  m_zero;

  always #5 clk = ~clk;

  // ULA stand-in
  always_comb begin
    res = '0;
    case (ula_op)
      3'd0: res = ~b;
      3'd1: res = a & b;
      3'd2: res = a | b;
      3'd3: res = a ^ b;
      3'd4: res = a + b;
      3'd5: res = a - b;
      3'd6: res = a << b;
      default: res = a >> b;
    endcase
  end

  ula_ctrl #(.ULA_OP(3), .BITS(BITS)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .instr_valid_in(valid),
    .instr_ready_out(ready),
    .instr_in(instr),
    .ula_op_out(ula_op),
    .a_out(a),
    .b_out(b),
    .result_in(res),
    .rd_sel_in(rd_sel),
    .rd_data_out(rd_data),
    .busy_out(busy),
    .illegal_out(illegal),
`ifdef ULA_CTRL_ZERO_FLAG_EN
    .zero_out(zero),
`endif
    .halted_out(halted)
  );

  function automatic int ref_alu(int op, int x, int y);
    int t;
    case (op)
      0: t = 255 - y;
      1: t = x & y;
      2: t = x | y;
      3: t = x ^ y;
      4: t = (x + y) % 256;
      5: t = (x - y + 256) % 256;
      6: t = (y >= 8) ? 0 : (x * (2 ** y)) % 256;
      default: t = (y >= 8) ? 0 : x / (2 ** y);
    endcase
    return t;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
    m_ill = 0;
    m_zero = 0;
  endfunction

  function automatic void model_alu(logic [7:0] ins);
    int ra = ins[3:2];
    int rb = ins[1:0];
    m[ra] = ref_alu(int'(ins[6:4]), m[ra], m[rb]);
    m_zero = (m[ra] == 0);
  endfunction

  function automatic void model_ldi(logic [7:0] ins, logic [7:0] imm);
    m[ins[3:2]] = imm;
    m_zero = (imm == 0);
  endfunction

  // Called at a falling edge; returns at the falling edge after transfer.
  task automatic send(input logic [7:0] byt);
    int n = 0;
    instr = byt;
    valid = 1'b1;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout byte=%h ready=%b want 1", byt, ready);
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({ready, busy, illegal, halted, ula_op, a, b} !== '0) begin
      fails++;
      $display("FAIL reset_outs rdy=%b busy=%b ill=%b hlt=%b op=%h a=%h b=%h want 0",
               ready, busy, illegal, halted, ula_op, a, b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", ready);
    end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      tests++;
      if (rd_data !== BITS'(m[i])) begin
        fails++;
        $display("FAIL reset_reg R%0d got %h want %h", i, rd_data, m[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ldi_add();
    send(8'h84); send(8'h05); model_ldi(8'h84, 8'h05);
    send(8'h88); send(8'h03); model_ldi(8'h88, 8'h03);
    send(8'h46);
    tests++;
    if (ula_op !== 3'b100 || a !== 8'h05 || b !== 8'h03 ||
        busy !== 1'b1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL exec_outs op=%b a=%h b=%h busy=%b rdy=%b want 100 05 03 1 0",
               ula_op, a, b, busy, ready);
    end
    model_alu(8'h46);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      tests++;
      if (rd_data !== BITS'(m[i])) begin
        fails++;
        $display("FAIL add_reg R%0d got %h want %h", i, rd_data, m[i]);
      end
    end
    tests++;
    if (m[1] != 8 || ready !== 1'b1) begin
      fails++;
      $display("FAIL add_ref R1=%0d rdy=%b want 8 1", m[1], ready);
    end
  endtask

  task automatic test_sub_wrap();
    send(8'h80); send(8'h00); model_ldi(8'h80, 8'h00);
`ifdef ULA_CTRL_ZERO_FLAG_EN
    tests++;
    if (zero !== 1'b1) begin
      fails++;
      $display("FAIL zero_after_ldi0 got %b want 1", zero);
    end
`endif
    send(8'h8C); send(8'h01); model_ldi(8'h8C, 8'h01);
    send(8'h53); model_alu(8'h53);
    @(negedge clk);
    rd_sel = 2'd0;
    #1;
    tests++;
    if (rd_data !== 8'hFF) begin
      fails++;
      $display("FAIL sub_wrap R0 got %h want ff", rd_data);
    end
`ifdef ULA_CTRL_ZERO_FLAG_EN
    tests++;
    if (zero !== 1'b0) begin
      fails++;
      $display("FAIL zero_after_sub got %b want 0", zero);
    end
`endif
  endtask

  task automatic test_imm_wait();
    send(8'h8C);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (ready !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL imm_wait cyc=%0d rdy=%b busy=%b want 1 1", i, ready, busy);
      end
      @(negedge clk);
    end
    send(8'hA5); model_ldi(8'h8C, 8'hA5);
    rd_sel = 2'd3;
    #1;
    tests++;
    if (rd_data !== 8'hA5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL imm_r3 got %h busy=%b want a5 0", rd_data, busy);
    end
  endtask

  task automatic test_illegal();
    send(8'h9F);
    m_ill = 1;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      tests++;
      if (rd_data !== BITS'(m[i])) begin
        fails++;
        $display("FAIL illegal_reg R%0d got %h want %h", i, rd_data, m[i]);
      end
    end
    tests++;
    if (illegal !== 1'b1 || ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_flag got %b rdy=%b want 1 1", illegal, ready);
    end
    send(8'h46); model_alu(8'h46);
    @(negedge clk);
    rd_sel = 2'd1;
    #1;
    tests++;
    if (rd_data !== BITS'(m[1]) || illegal !== 1'b1) begin
      fails++;
      $display("FAIL illegal_then_add R1=%h ill=%b want %h 1", rd_data, illegal, m[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] ins, imm;
    int k;
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      if (k < 6) begin
        ins = {1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
        send(ins);
        model_alu(ins);
        @(negedge clk);
      end else if (k < 9) begin
        ins = {4'b1000, 4'($urandom_range(0, 15))};
        imm = 8'($urandom_range(0, 255));
        if (k == 8) imm = 8'h00;
        send(ins);
        send(imm);
        model_ldi(ins, imm);
      end else begin
        ins = {4'($urandom_range(9, 14)), 4'($urandom_range(0, 15))};
        send(ins);
        m_ill = 1;
      end
      for (int i = 0; i < 4; i++) begin
        rd_sel = 2'(i);
        #1;
        tests++;
        if (rd_data !== BITS'(m[i])) begin
          fails++;
          $display("FAIL rand_reg n=%0d ins=%h R%0d got %h want %h",
                   n, ins, i, rd_data, m[i]);
        end
      end
      tests++;
      if (illegal !== m_ill) begin
        fails++;
        $display("FAIL rand_illegal n=%0d got %b want %b", n, illegal, m_ill);
      end
`ifdef ULA_CTRL_ZERO_FLAG_EN
      tests++;
      if (zero !== m_zero) begin
        fails++;
        $display("FAIL rand_zero n=%0d got %b want %b", n, zero, m_zero);
      end
`endif
    end
  endtask

  task automatic test_halt();
    send(8'hF0);
    instr = 8'h84;
    valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr = 8'($urandom_range(0, 255));
      tests++;
      if (halted !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL halt_state cyc=%0d hlt=%b rdy=%b busy=%b want 1 0 0",
                 i, halted, ready, busy);
      end
      @(negedge clk);
    end
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      tests++;
      if (rd_data !== BITS'(m[i])) begin
        fails++;
        $display("FAIL halt_reg R%0d got %h want %h", i, rd_data, m[i]);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    tests++;
    if (halted !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL halt_reset hlt=%b rdy=%b want 0 1", halted, ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    send(8'h84); send(8'h3C); model_ldi(8'h84, 8'h3C);
    send(8'h35);
    tests++;
    if (busy !== 1'b1 || a !== 8'h3C) begin
      fails++;
      $display("FAIL xor_exec busy=%b a=%h want 1 3c", busy, a);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({ready, busy, illegal, halted, ula_op, a, b} !== '0) begin
      fails++;
      $display("FAIL midexec_outs rdy=%b busy=%b ill=%b hlt=%b op=%h a=%h b=%h want 0",
               ready, busy, illegal, halted, ula_op, a, b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      tests++;
      if (rd_data !== BITS'(m[i])) begin
        fails++;
        $display("FAIL midexec_reg R%0d got %h want %h", i, rd_data, m[i]);
      end
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL midexec_ready got %b want 1", ready);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ldi_add();
    test_sub_wrap();
    test_imm_wait();
    test_illegal();
    test_random();
    test_halt();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
- Multi-cycle instruction sequencer and register file that drives the 8-op ULA (ALU) from the control side.
- Accepts 8-bit instructions over a valid/ready handshake and holds a 4-entry register file.
- Presents opcode and operands to the ULA, captures the ULA result and writes it back.
- Sits between the instruction source (fetch unit or testbench) and the combinational ULA.

Parameters:
- ULA_OP, 3, width of the ULA operation select.
- BITS, 8, datapath and register width (minimum 8).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- instr_valid_in  input  1  instruction byte on instr_in is valid.
- instr_ready_out  output  1  block accepts a byte this cycle.
- instr_in  input  8  instruction or immediate byte.
- ula_op_out  output  ULA_OP  operation select to the ULA.
- a_out  output  BITS  ULA operand A.
- b_out  output  BITS  ULA operand B.
- result_in  input  BITS  ULA result, combinational from a_out, b_out and ula_op_out.
- rd_sel_in  input  2  debug register select.
- rd_data_out  output  BITS  R[rd_sel_in], combinational read.
- busy_out  output  1  high in any state other than IDLE and HALT.
- illegal_out  output  1  sticky illegal-opcode flag.
- halted_out  output  1  high in HALT.

Behaviour:
- Instruction encoding: [7:4] opcode, [3:2] ra (destination and operand A), [1:0] rb (operand B).
- Opcodes 0000-0111 are ALU operations: ula_op_out = instr[6:4], and the result goes to R[ra]. The ops are 000 NOT b, 001 AND, 010 OR, 011 XOR, 100 ADD, 101 SUB, 110 SHL, 111 SHR.
- Opcode 1000 is LDI: the next accepted byte is zero-extended to BITS and written to R[ra]. rb is ignored.
- Opcode 1111 is HALT. Opcodes 1001-1110 are illegal.
- A handshake transfer occurs when instr_valid_in and instr_ready_out are both high at a rising edge.
- instr_ready_out is high only in IDLE and IMM. It is combinational from state and does not depend on instr_valid_in.
- States and transitions:
  - IDLE, on ALU-op transfer: register ula_op_out = instr[6:4], a_out = R[ra], b_out = R[rb] and the latched ra; go to EXEC.
  - IDLE, on LDI transfer: latch ra; go to IMM.
  - IDLE, on HALT transfer: go to HALT.
  - IDLE, on illegal transfer: set illegal_out; registers unchanged; stay in IDLE.
  - IDLE, no transfer: hold.
  - EXEC, one cycle only: at its closing edge, R[latched ra] <= result_in; go to IDLE.
  - IMM: wait indefinitely for a transfer. On transfer, R[latched ra] <= {zeros, instr_in}; go to IDLE.
  - HALT: terminal. instr_ready_out = 0 and busy_out = 0 until reset.
- Latency and throughput:
  - ALU instruction: result visible on rd_data_out 2 cycles after its transfer edge; next byte accepted 2 edges after the previous transfer.
  - LDI: visible 1 cycle after the immediate transfer.
- ula_op_out, a_out and b_out hold their last values outside EXEC.
- Arithmetic width: the result is taken as BITS bits from the ULA. ADD/SUB wrap modulo 2^BITS. Shift amount is the full b_out value.
- ra == rb is legal: a_out and b_out carry the same pre-write value.
- A write and a debug read of the same register in the same cycle returns the old value until the edge.
- Reset (async assert, any state):
  - State -> IDLE; R0-R3 = 0.
  - ula_op_out = 0, a_out = 0, b_out = 0.
  - illegal_out = 0, halted_out = 0, busy_out = 0.
  - An in-flight EXEC or IMM is discarded with no writeback.
  - instr_ready_out becomes 1 once reset deasserts.

Optional Feature:
- Macro: ULA_CTRL_ZERO_FLAG_EN.
- Defined:
  - Adds output zero_out (1 bit), reset 0.
  - On every register writeback (EXEC or IMM), zero_out <= (written value == 0).
  - Unchanged on illegal opcodes and HALT.
- Undefined: the port does not exist and there is no extra logic; all other behaviour is identical.

Test Plan:
- Reset, LDI R1 (0x84, 0x05), LDI R2 (0x88, 0x03), ADD R1,R2 (0x46) -> in EXEC ula_op_out = 100, a_out = 0x05, b_out = 0x03; afterwards R1 = 0x08, R2 = 0x03.
- LDI R0, 0x00; LDI R3, 0x01; SUB R0,R3 (0x53) -> R0 = 0xFF (wrap). With ULA_CTRL_ZERO_FLAG_EN, zero_out = 1 after LDI R0,0 and 0 after the SUB.
- LDI opcode 0x8C, then instr_valid_in low for 10 cycles -> state IMM, instr_ready_out = 1, busy_out = 1; then byte 0xA5 -> R3 = 0xA5.
- Instruction 0x9F -> illegal_out = 1 and stays 1, R0-R3 unchanged; next ADD executes normally.
- HALT 0xF0, then instr_valid_in held high for 20 cycles -> halted_out = 1, instr_ready_out = 0, no register change; reset -> halted_out = 0, instr_ready_out = 1.
- rst_n_in pulsed low mid-EXEC of XOR R1,R1 with R1 = 0x3C -> all outputs 0 immediately (before the next edge), no writeback, R1 = 0x00.
